// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: sends a WIDTH-bit word LSB first, each bit held BIT_DIV cycles.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
  parameter int WIDTH   = 4,
  parameter int BIT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(BIT_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef PISO_TX_PARITY_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               so_q, so_d;
  logic               so_valid_q, so_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef PISO_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif
  logic               bit_end;

  assign din_ready = (state_q == IDLE);
  assign bit_end   = (div_q == LAST_DIV);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    so_d       = so_q;
    so_valid_d = so_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (din_valid && din_ready) begin
          // Bit 0 is presented on so in the very cycle after acceptance.
          shift_d    = din;
          bit_cnt_d  = '0;
          div_d      = '0;
          so_d       = din[0];
          so_valid_d = 1'b1;
          busy_d     = 1'b1;
`ifdef PISO_TX_PARITY_EN
          parity_d   = ^din;
`endif
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_end) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
            so_d       = parity_q;
            state_d    = PAR;
`else
            so_d       = 1'b0;
            so_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            so_d      = shift_q[1];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

`ifdef PISO_TX_PARITY_EN
      PAR: begin
        if (bit_end) begin
          div_d      = '0;
          so_d       = 1'b0;
          so_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif

      DONE: begin
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PISO_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
